port_uart_tx: RTL and testbench
===============================

Name: port_uart_tx

Overview:
- Serial transmitter at the far end of the processor's parallel output port. It turns bytes written to an OUT port into 8N1 UART frames on a single pin.
- Provides a one-byte holding buffer in front of the shift register, so software can queue the next byte while the current frame is on the line.
- Returns a status byte meant to be wired to an IN port, so programs can poll it before writing.

Parameters:
- CLKS_PER_BIT, 868, system clocks per UART bit (100 MHz / 115200). Legal range 2..65535.

Ports:
- CLK100MHZ  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte from the processor OUT port register.
- tx_stb  input  1  one-cycle write strobe; tx_data is valid in the same cycle.
- status_rd  input  1  one-cycle pulse; clears the sticky overrun flag.
- tx  output  1  serial line; idles high.
- status  output  8  {5'b0, overrun, hold_full, busy}, for an IN port.

Behaviour:
- Reset (rst=1 at a clock edge) clears every register. After that edge:
  - tx=1, status=8'h00, FSM=IDLE.
  - Holding register and shifter are cleared.
  - Baud counter=0 and bit index=0.
- Reset takes priority over every other input.
- Reset mid-frame: tx returns high on the next edge. The in-flight byte and the held byte are discarded. No partial stop bit is sent.
- Holding buffer:
  - tx_stb with hold_full=0: capture tx_data, set hold_full.
  - tx_stb with hold_full=1, and no transfer to the shifter in that cycle: byte dropped, overrun set to 1.
  - tx_stb in the same cycle the holding byte moves to the shifter: new byte accepted, hold_full stays 1, no overrun.
- overrun handling:
  - Sticky; cleared only by status_rd or rst.
  - status_rd and a new overrun in the same cycle: overrun ends at 1 (set wins).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If hold_full, load shifter from the holding byte, clear hold_full, go to START, drive tx=0.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive shifter bit[index], LSB first, for CLKS_PER_BIT cycles each. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if hold_full, load and go straight to START (no idle gap); otherwise go to IDLE.
- busy = FSM not IDLE. hold_full reflects the holding register. status is registered state, never a combinational path from tx_stb.
- Latency: tx_stb sampled at edge E with the line idle → hold_full=1 after E → tx=0 after E+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles, start-bit fall to end of stop bit.
- Baud counter runs 0..CLKS_PER_BIT-1, resets to 0 on each bit boundary, and wraps without drift. Bit index is 3 bits.
- Throughput: continuous streaming when software writes each new byte while busy=1 and hold_full=0.
- tx_stb is ignored while rst=1.

Test Plan:
- Reset: CLKS_PER_BIT=4, rst high for 2 cycles, then low → tx=1 and status=8'h00; hold 20 cycles with no stb → no change.
- Single byte: tx_stb with tx_data=8'hA5 → tx low 2 edges later. Over 4-cycle bit slots the line reads 0,1,0,1,0,0,1,0,1,1. busy drops after 40 cycles; status returns to 8'h00.
- Back-to-back: write 8'h55, then write 8'h0F while busy=1 and hold_full=0 → second start bit immediately follows the first stop bit with no gap. hold_full=1 until the first frame ends.
- Overrun: with busy=1 and hold_full=1, write 8'hFF → status[2]=1 and the byte is never sent. Pulse status_rd → status[2]=0. Same-cycle status_rd and overrun → status[2]=1.
- Simultaneous transfer: tx_stb with 8'h3C in the exact cycle IDLE loads 8'h11 → 8'h11 is sent, then 8'h3C, and overrun stays 0.
- Reset mid-frame: assert rst during data bit 3 of 8'h00 with 8'h81 held → tx=1 next edge, status=8'h00, and no further frames appear.

Source files
------------

// File: rtl/port_uart_tx.sv
// port_uart_tx: 8N1 UART transmitter fed from a processor OUT port.
// A one-byte holding register sits in front of the shift register so the
// next byte can be queued while the current frame is on the line. A status
// byte {5'b0, overrun, hold_full, busy} is exported for an IN port.
module port_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK100MHZ,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_stb,
    input  logic       status_rd,
    output logic       tx,
    output logic [7:0] status
);

    // Last count value of a bit slot; the counter runs 0..CLKS_PER_BIT-1.
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  idx_q, idx_d;
    logic        tx_q, tx_d;
    logic        overrun_q, overrun_d;

    logic        bit_done;
    logic        load;
    logic        overrun_set;

    // A bit slot ends when the baud counter reaches its last value.
    assign bit_done = (baud_q == BAUD_LAST);

    // Frame sequencer: next state, line level, baud counter and bit index.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = 16'd0;
                idx_d  = 3'd0;
                if (hold_full_q) begin
                    load    = 1'b1;
                    shift_d = hold_q;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end

            START: begin
                if (bit_done) begin
                    baud_d  = 16'd0;
                    idx_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    baud_d = 16'd0;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[idx_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    baud_d = 16'd0;
                    if (hold_full_q) begin
                        // Chain straight into the next start bit, no idle gap.
                        load    = 1'b1;
                        shift_d = hold_q;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                baud_d  = 16'd0;
                idx_d   = 3'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Holding buffer and sticky overrun flag.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        overrun_set = 1'b0;

        if (load) begin
            // The held byte moves to the shifter this cycle, so a write in
            // the same cycle always finds room.
            hold_full_d = tx_stb;
            if (tx_stb) begin
                hold_d = tx_data;
            end
        end else if (tx_stb) begin
            if (!hold_full_q) begin
                hold_d      = tx_data;
                hold_full_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end

        // A new overrun beats a simultaneous status read.
        overrun_d = overrun_set | (overrun_q & ~status_rd);
    end

    // State registers with synchronous reset; line idles high.
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_q     <= 8'h00;
            baud_q      <= 16'd0;
            idx_q       <= 3'd0;
            tx_q        <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            baud_q      <= baud_d;
            idx_q       <= idx_d;
            tx_q        <= tx_d;
            overrun_q   <= overrun_d;
        end
    end

    assign tx     = tx_q;
    assign status = {5'b00000, overrun_q, hold_full_q, (state_q != IDLE)};

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx at 4 clocks per bit: directed scenarios followed by
// randomized software-style writes, with a line-level UART receiver that
// decodes frames and compares them against the queue of accepted bytes.
module tb_port_uart_tx;

    localparam int B = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_stb;
    logic       status_rd;
    logic       tx;
    logic [7:0] status;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    port_uart_tx #(.CLKS_PER_BIT(B)) dut (
        .CLK100MHZ (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_stb    (tx_stb),
        .status_rd (status_rd),
        .tx        (tx),
        .status    (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; presents one write strobe across the next rising edge.
    task automatic write_byte(input logic [7:0] b);
        tx_stb  = 1'b1;
        tx_data = b;
        @(negedge clk);
        tx_stb  = 1'b0;
    endtask

    task automatic pulse_rd();
        status_rd = 1'b1;
        @(negedge clk);
        status_rd = 1'b0;
    endtask

    // Called at the falling edge right after the start bit began; samples
    // every bit slot one falling edge into the slot.
    task automatic check_frame(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        @(negedge clk);
        check($sformatf("frame_%02h_bit0", b), tx, fr[0]);
        for (int s = 1; s < 10; s++) begin
            repeat (B) @(negedge clk);
            check($sformatf("frame_%02h_bit%0d", b, s), tx, fr[s]);
        end
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (status === 8'h00) break;
            @(negedge clk);
        end
        check("wait_idle", status, 8'h00);
    endtask

    // Line receiver: finds a start bit, samples each slot at its centre and
    // abandons any frame during which reset was seen.
    initial begin
        logic [7:0] by;
        logic       s0, sp;
        bit         abort;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                abort = 1'b0;
                by = 8'h00;
                s0 = 1'b1;
                sp = 1'b0;
                for (int k = 1; k <= 38; k++) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                    if (k == 2) s0 = tx;
                    if (k >= 6 && k <= 34 && ((k - 2) % 4) == 0) by[(k - 6) / 4] = tx;
                    if (k == 38) sp = tx;
                end
                if (!abort) begin
                    check("rx_start_bit", s0, 1'b0);
                    check("rx_stop_bit", sp, 1'b1);
                    rx_q.push_back(by);
                end
            end
        end
    end

    initial begin
        int         n_before;
        logic [7:0] b;
        rst       = 1'b1;
        tx_data   = 8'h00;
        tx_stb    = 1'b0;
        status_rd = 1'b0;

        // Reset and quiet line
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_tx", tx, 1'b1);
        check("reset_status", status, 8'h00);
        mon_en = 1'b1;
        repeat (20) @(negedge clk);
        check("quiet_tx", tx, 1'b1);
        check("quiet_status", status, 8'h00);

        // Single byte A5
        write_byte(8'hA5);
        exp_q.push_back(8'hA5);
        check("single_held_status", status, 8'h02);
        check("single_tx_still_high", tx, 1'b1);
        @(negedge clk);
        check("single_start_fall", tx, 1'b0);
        check("single_busy_status", status, 8'h01);
        check_frame(8'hA5);
        repeat (2) @(negedge clk);
        check("single_busy_before_end", status, 8'h01);
        @(negedge clk);
        check("single_idle_after_40", status, 8'h00);

        // Back-to-back 55 then 0F
        write_byte(8'h55);
        exp_q.push_back(8'h55);
        @(negedge clk);
        check("b2b_busy_empty", status, 8'h01);
        write_byte(8'h0F);
        exp_q.push_back(8'h0F);
        check("b2b_held", status, 8'h03);
        repeat (38) @(negedge clk);
        check("b2b_held_to_end", status, 8'h03);
        check("b2b_first_stop", tx, 1'b1);
        @(negedge clk);
        check("b2b_no_gap_start", tx, 1'b0);
        check("b2b_hold_moved", status, 8'h01);
        wait_idle(200);

        // Overrun
        write_byte(8'h22);
        exp_q.push_back(8'h22);
        @(negedge clk);
        write_byte(8'h33);
        exp_q.push_back(8'h33);
        check("ovr_held", status, 8'h03);
        write_byte(8'hFF);
        check("ovr_set", status, 8'h07);
        pulse_rd();
        check("ovr_cleared", status, 8'h03);
        status_rd = 1'b1;
        write_byte(8'hFF);
        status_rd = 1'b0;
        check("ovr_set_wins", status, 8'h07);
        pulse_rd();
        check("ovr_cleared_again", status, 8'h03);
        wait_idle(300);

        // Write in the exact cycle IDLE loads the held byte
        write_byte(8'h11);
        exp_q.push_back(8'h11);
        write_byte(8'h3C);
        exp_q.push_back(8'h3C);
        check("simul_status", status, 8'h03);
        wait_idle(300);
        check("simul_no_overrun", status[2], 1'b0);

        // Reset during data bit 3 with a byte held
        n_before = rx_q.size();
        write_byte(8'h00);
        write_byte(8'h81);
        repeat (17) @(negedge clk);
        check("midrst_pre_status", status, 8'h03);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_high", tx, 1'b1);
        check("midrst_status", status, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("midrst_line_quiet", tx, 1'b1);
        check("midrst_status_quiet", status, 8'h00);
        check("midrst_no_frames", rx_q.size(), n_before);

        // Randomized writes, each issued only once the holding slot is free
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 200; i++) begin
                if (status[1] === 1'b0) break;
                @(negedge clk);
            end
            check("rand_hold_free", status[1], 1'b0);
            repeat ($urandom_range(0, 12)) @(negedge clk);
            b = 8'($urandom);
            write_byte(b);
            exp_q.push_back(b);
            check("rand_accepted", status[2:1], 2'b01);
        end
        wait_idle(400);
        repeat (4) @(negedge clk);

        // Every accepted byte on the line, in order, and nothing else
        check("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) begin
                check($sformatf("rx_byte_%0d", i), rx_q[i], exp_q[i]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
